// File: rtl/atmega_tim_int_arbiter.sv
// Interrupt scheduler between a 16-bit timer's level flags and the core's interrupt controller.
// Serves one pending flag at a time: request, wait for ack, pulse that flag's clear, let it drop.
module atmega_tim_int_arbiter #(
  parameter int unsigned NUM_SRC     = 5,
  parameter int unsigned VECT_W      = 6,
  parameter int unsigned VECT_BASE   = 10,
  parameter int unsigned VECT_STEP   = 1,
  parameter string       ROUND_ROBIN = "FALSE",
  parameter int unsigned CLR_WAIT    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               global_en,
  input  logic [NUM_SRC-1:0] src_int,
  output logic [NUM_SRC-1:0] src_int_rst,
  output logic               int_req,
  output logic [VECT_W-1:0]  int_vect,
  input  logic               int_ack,
  output logic               busy
);

  localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned CNT_W = 4;
  localparam bit          RR_EN = (ROUND_ROBIN == "TRUE");

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_CLR  = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  logic [1:0]         state, state_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               int_req_d;
  logic [VECT_W-1:0]  int_vect_d;
  logic [NUM_SRC-1:0] src_int_rst_d;

  logic [IDX_W-1:0]   scan_base;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  logic [VECT_W-1:0]  win_vect;

  // Winner: first set flag scanning upward from scan_base with wrap (base 0 in fixed mode)
  always_comb begin
    win_idx   = '0;
    win_any   = 1'b0;
    scan_base = RR_EN ? rr_ptr : '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (!win_any && src_int[IDX_W'((32'(scan_base) + k) % NUM_SRC)]) begin
        win_any = 1'b1;
        win_idx = IDX_W'((32'(scan_base) + k) % NUM_SRC);
      end
    end
    win_vect = VECT_W'(VECT_BASE + 32'(win_idx) * VECT_STEP);
  end

  always_comb begin
    state_d       = state;
    idx_d         = idx;
    rr_ptr_d      = rr_ptr;
    cnt_d         = cnt;
    int_req_d     = int_req;
    int_vect_d    = int_vect;
    src_int_rst_d = '0;
    case (state)
      S_IDLE: begin
        if (global_en && win_any) begin
          state_d    = S_REQ;
          idx_d      = win_idx;
          int_req_d  = 1'b1;
          int_vect_d = win_vect;
        end
      end
      S_REQ: begin
        // Acknowledge takes precedence over a simultaneous withdraw condition
        if (int_ack) begin
          int_req_d     = 1'b0;
          src_int_rst_d = NUM_SRC'(1) << idx;
          state_d       = S_CLR;
        end else if (!src_int[idx] || !global_en) begin
          int_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_CLR: begin
        rr_ptr_d = (idx == IDX_W'(NUM_SRC - 1)) ? '0 : idx + IDX_W'(1);
        cnt_d    = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // Hold off until the timer has actually dropped the flag, bounded by CLR_WAIT cycles
        if (!src_int[idx] || cnt == CNT_W'(CLR_WAIT - 1)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      rr_ptr      <= '0;
      cnt         <= '0;
      int_req     <= 1'b0;
      int_vect    <= '0;
      src_int_rst <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      rr_ptr      <= rr_ptr_d;
      cnt         <= cnt_d;
      int_req     <= int_req_d;
      int_vect    <= int_vect_d;
      src_int_rst <= src_int_rst_d;
      busy        <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_atmega_tim_int_arbiter.sv
// Scoreboard bench: three arbiter configurations share random stimulus and are checked
// against a transaction-style reference model of the interrupt service protocol.
module tb_atmega_tim_int_arbiter;

  localparam int NU = 3;
  localparam int VB [NU] = '{10, 10, 62};
  localparam int VS [NU] = '{1, 1, 3};
  localparam int RR [NU] = '{0, 1, 0};
  localparam int CW [NU] = '{2, 2, 1};

  typedef struct packed {
    logic [NU-1:0]      req;
    logic [NU-1:0][5:0] vect;
    logic [NU-1:0][4:0] srst;
    logic [NU-1:0]      busy;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       global_en;
  logic [4:0] src_int;
  logic       int_ack;

  logic       req  [NU];
  logic [5:0] vect [NU];
  logic [4:0] srst [NU];
  logic       bsy  [NU];

  int n_vec = 0;
  int n_err = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  // Model: which source is requesting, being cleared, or guarded while its flag drains
  int req_src [NU];
  int clr_src [NU];
  int grd_src [NU];
  int grd_left[NU];
  int ptr     [NU];

  atmega_tim_int_arbiter #(.NUM_SRC(5), .VECT_W(6), .VECT_BASE(10), .VECT_STEP(1),
                           .ROUND_ROBIN("FALSE"), .CLR_WAIT(2)) u0 (
    .clk(clk), .rst(rst), .global_en(global_en), .src_int(src_int),
    .src_int_rst(srst[0]), .int_req(req[0]), .int_vect(vect[0]),
    .int_ack(int_ack), .busy(bsy[0]));

  atmega_tim_int_arbiter #(.NUM_SRC(5), .VECT_W(6), .VECT_BASE(10), .VECT_STEP(1),
                           .ROUND_ROBIN("TRUE"), .CLR_WAIT(2)) u1 (
    .clk(clk), .rst(rst), .global_en(global_en), .src_int(src_int),
    .src_int_rst(srst[1]), .int_req(req[1]), .int_vect(vect[1]),
    .int_ack(int_ack), .busy(bsy[1]));

  atmega_tim_int_arbiter #(.NUM_SRC(5), .VECT_W(6), .VECT_BASE(62), .VECT_STEP(3),
                           .ROUND_ROBIN("FALSE"), .CLR_WAIT(1)) u2 (
    .clk(clk), .rst(rst), .global_en(global_en), .src_int(src_int),
    .src_int_rst(srst[2]), .int_req(req[2]), .int_vect(vect[2]),
    .int_ack(int_ack), .busy(bsy[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  function automatic int pick(input int base, input logic [4:0] s);
    for (int k = 0; k < 5; k++) begin
      if (s[3'((base + k) % 5)]) return (base + k) % 5;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < NU; u++) begin
      req_src[u] = -1; clr_src[u] = -1; grd_src[u] = -1; grd_left[u] = 0; ptr[u] = 0;
    end
  endtask

  // Advance every model by one clock edge with the given inputs and queue the outcome
  task automatic model_step(input logic ge, input logic [4:0] s, input logic ack);
    exp_t e;
    e = '0;
    for (int u = 0; u < NU; u++) begin
      if (req_src[u] >= 0) begin
        if (ack) begin
          clr_src[u] = req_src[u];
          req_src[u] = -1;
        end else if (!s[req_src[u]] || !ge) begin
          req_src[u] = -1;
        end
      end else if (clr_src[u] >= 0) begin
        ptr[u]      = (clr_src[u] + 1) % 5;
        grd_src[u]  = clr_src[u];
        grd_left[u] = CW[u];
        clr_src[u]  = -1;
      end else if (grd_src[u] >= 0) begin
        grd_left[u]--;
        if (!s[grd_src[u]] || grd_left[u] == 0) grd_src[u] = -1;
      end else if (ge) begin
        req_src[u] = pick(RR[u] != 0 ? ptr[u] : 0, s);
      end
      e.req[u]  = (req_src[u] >= 0);
      e.vect[u] = (req_src[u] >= 0) ? 6'((VB[u] + req_src[u] * VS[u]) % 64) : 6'd0;
      e.srst[u] = (clr_src[u] >= 0) ? (5'd1 << clr_src[u]) : 5'd0;
      e.busy[u] = (req_src[u] >= 0) || (clr_src[u] >= 0) || (grd_src[u] >= 0);
    end
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs at the falling edge, record expectation, wait for next fall
  task automatic cycle(input logic ge, input logic [4:0] s, input logic ack);
    global_en = ge;
    src_int   = s;
    int_ack   = ack;
    model_step(ge, s, ack);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int u = 0; u < NU; u++) begin
      chk($sformatf("%s u%0d int_req", tag, u), int'(req[u]), 0);
      chk($sformatf("%s u%0d int_vect", tag, u), int'(vect[u]), 0);
      chk($sformatf("%s u%0d src_int_rst", tag, u), int'(srst[u]), 0);
      chk($sformatf("%s u%0d busy", tag, u), int'(bsy[u]), 0);
    end
  endtask

  // Monitor: compare registered outputs just after each rising edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      for (int u = 0; u < NU; u++) begin
        chk($sformatf("u%0d int_req", u), int'(req[u]), int'(mon_e.req[u]));
        if (mon_e.req[u]) chk($sformatf("u%0d int_vect", u), int'(vect[u]), int'(mon_e.vect[u]));
        chk($sformatf("u%0d src_int_rst", u), int'(srst[u]), int'(mon_e.srst[u]));
        chk($sformatf("u%0d busy", u), int'(bsy[u]), int'(mon_e.busy[u]));
      end
    end
  end

  initial begin
    logic [4:0] s;
    rst = 1'b0; global_en = 1'b0; src_int = '0; int_ack = 1'b0;
    model_reset();
    #3;
    check_reset_outputs("power-on reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Fixed pattern 10110 with random acks
    for (int i = 0; i < 40; i++) cycle(1'b1, 5'b10110, 1'($urandom_range(1)));

    // All flags high: exercises rotation and flag-held-through-guard timeout
    for (int i = 0; i < 60; i++) cycle(1'b1, 5'h1F, 1'($urandom_range(1)));

    // Asynchronous reset while requesting
    cycle(1'b1, 5'h1F, 1'b0);
    cycle(1'b1, 5'h1F, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("mid-request reset");
    model_reset();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Random flags that rise and fall, occasional global disable, random acks
    s = 5'b00000;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 5; b++) if ($urandom_range(7) == 0) s[b] = ~s[b];
      cycle(1'($urandom_range(9) != 0), s, 1'($urandom_range(2) == 0));
    end

    // Ack coinciding with global disable, dense
    for (int i = 0; i < 300; i++) begin
      for (int b = 0; b < 5; b++) if ($urandom_range(3) == 0) s[b] = ~s[b];
      cycle(1'($urandom_range(2) != 0), s, 1'($urandom_range(1)));
    end

    cycle(1'b0, 5'd0, 1'b0);
    @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
